// File: rtl/multiply_seq_if.sv
// Operand/result bundle between the execute-stage controller and multiply_seq.
// The controller drives the master side and the multiplier drives the slave side.
interface multiply_seq_if #(
  parameter int WIDTH = 32
);
  logic                 mult_begin;
  logic                 mult_signed;
  logic [WIDTH-1:0]     mult_op1;
  logic [WIDTH-1:0]     mult_op2;
  logic [2*WIDTH-1:0]   product;
  logic                 mult_end;
  logic                 mult_busy;

  modport master (
    output mult_begin, mult_signed, mult_op1, mult_op2,
    input  product, mult_end, mult_busy
  );

  modport slave (
    input  mult_begin, mult_signed, mult_op1, mult_op2,
    output product, mult_end, mult_busy
  );
endinterface

// File: rtl/multiply_seq.sv
// Iterative shift-add multiplier that works on operand magnitudes and applies
// the result sign once, when the product is registered.
module multiply_seq #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  multiply_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic                 begin_q;
  logic                 start;
  logic                 sign;
  logic [CW-1:0]        counter;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   product_r;
  logic [WIDTH-1:0]     op1_mag;
  logic [WIDTH-1:0]     op2_mag;

  // The most-negative operand negates to itself, which is its correct unsigned magnitude.
  assign op1_mag = (bus.mult_signed && bus.mult_op1[WIDTH-1]) ?
                   (~bus.mult_op1 + WIDTH'(1)) : bus.mult_op1;
  assign op2_mag = (bus.mult_signed && bus.mult_op2[WIDTH-1]) ?
                   (~bus.mult_op2 + WIDTH'(1)) : bus.mult_op2;

  always_comb begin
    start      = bus.mult_begin && !begin_q && (state == IDLE);
    state_next = state;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        if (!bus.mult_begin)
          state_next = IDLE;
        else if (counter == '0)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // CALC runs WIDTH add/shift steps, then one extra cycle that registers the
  // signed product so it is valid in the same cycle mult_end is decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      begin_q   <= 1'b0;
      sign      <= 1'b0;
      counter   <= '0;
      mplier    <= '0;
      mcand     <= '0;
      acc       <= '0;
      product_r <= '0;
    end else begin
      begin_q <= bus.mult_begin;
      state   <= state_next;
      if (start) begin
        mcand   <= {{WIDTH{1'b0}}, op1_mag};
        mplier  <= op2_mag;
        acc     <= '0;
        sign    <= bus.mult_signed && (bus.mult_op1[WIDTH-1] ^ bus.mult_op2[WIDTH-1]);
        counter <= CW'(WIDTH);
      end else if (state == CALC && bus.mult_begin) begin
        if (counter != '0) begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter - CW'(1);
        end else begin
          product_r <= sign ? (~acc + (2*WIDTH)'(1)) : acc;
        end
      end
    end
  end

  assign bus.product   = product_r;
  assign bus.mult_end  = (state == DONE);
  assign bus.mult_busy = (state == CALC) || (state == DONE);
endmodule

// File: doc/multiply_seq.md
Name: multiply_seq

Overview:
- Parametrised iterative shift-add multiplier; successor to the fixed 32-bit `multiply` unit.
- Adds configurable operand width, per-operation signed/unsigned mode, a busy flag, abort on begin-drop and a synchronous reset.
- Sits beside the ALU in the CPU execute stage. The controller raises `mult_begin`, holds it, and waits for `mult_end`.

Parameters:
- WIDTH, 32, operand width in bits (>=4); product is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mult_begin  input  1  start/hold request; must stay high for the whole operation.
- mult_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at start.
- mult_op1  input  WIDTH  multiplicand; sampled at start.
- mult_op2  input  WIDTH  multiplier; sampled at start.
- product  output  2*WIDTH  registered result; holds its value until the next completion.
- mult_end  output  1  one-cycle pulse; product is valid in the same cycle.
- mult_busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (rst high at an edge): state=IDLE, product=0, mult_end=0, mult_busy=0, begin_q=0, counter=0. Reset overrides everything, including mid-operation; no mult_end is produced for the aborted operation.
- begin_q is mult_begin registered each cycle.
- start = mult_begin & ~begin_q & (state==IDLE). The start is rising-edge qualified: holding mult_begin high produces exactly one operation.
- The first edge after reset with mult_begin already high counts as a rising edge.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on start:
  - latch |op1| and |op2| (two's-complement magnitude only if mult_signed=1 and the operand MSB is 1);
  - latch result sign = mult_signed & (op1[W-1] ^ op2[W-1]);
  - clear the 2W-bit accumulator;
  - counter = WIDTH.
- CALC, each cycle:
  - if multiplier LSB is 1, accumulator += multiplicand (multiplicand shifted into 2W-bit position);
  - multiplicand <<= 1, multiplier >>= 1, counter -= 1;
  - after WIDTH cycles go to DONE.
- CALC abort: if mult_begin is sampled low during CALC, go to IDLE immediately. product is unchanged, no mult_end, mult_busy drops the next cycle.
- DONE (one cycle):
  - product <= sign ? -acc : acc (2W-bit two's complement);
  - mult_end=1 is combinationally decoded from DONE, aligned so that product is already updated in that cycle;
  - next state IDLE.
  - Implementation choice: register the product on the CALC->DONE transition so product and mult_end coincide.
- Latency: start sampled at edge E0; mult_end and the valid product are visible during the cycle after edge E0+WIDTH+1, i.e. WIDTH+2 edges start-to-end. Repeat rate is one operation per WIDTH+3 cycles minimum, because a begin low cycle is required.
- mult_busy = (state==CALC) | (state==DONE).
- Ignored inputs:
  - mult_op*/mult_signed changes after start;
  - a rising mult_begin while not IDLE; the controller must drop and re-raise it.
- Width rules:
  - the most-negative operand magnitude 2^(W-1) fits in W unsigned bits;
  - (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) fits in 2W signed bits; no overflow in any mode.
- Zero operands still take the full WIDTH cycles; there is no early termination.

Test Plan:
- WIDTH=32, rst 2 cycles, then mult_begin=1 held, signed=0, op1=9, op2=5 -> single mult_end pulse, product=64'h0000_0000_0000_002D. No second pulse while begin stays high; mult_busy is high from the edge after start until mult_end.
- signed=1, op1=32'hFFFF_FFFD (-3), op2=7 -> product=64'hFFFF_FFFF_FFFF_FFEB. With signed=0 and the same operands -> product=64'h0000_0006_FFFF_FFEB.
- signed=0, op1=op2=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001. signed=1, op1=op2=32'h8000_0000 -> product=64'h4000_0000_0000_0000.
- Start 6*7 (result 42); drop mult_begin at cycle 10 of CALC -> no mult_end, product keeps its previous value, state IDLE. Re-raise mult_begin -> 42 after full latency.
- rst asserted at cycle 5 of CALC -> all outputs 0 next cycle, no mult_end. Begin still high after rst release -> a new operation starts and completes normally.
- WIDTH=8 instance, signed=1, op1=8'h80, op2=8'h7F -> product=16'hC080 after 10 edges. signed=0 -> product=16'h3F80.
